// File: rtl/intc_pkg.sv
// Shared constants for the iZero interrupt controller.
// Interrupt codes, FSM state encoding and priority helpers.
package intc_pkg;

  localparam logic [1:0] INT_NONE    = 2'd0;
  localparam logic [1:0] INT_QUANTUM = 2'd1;
  localparam logic [1:0] INT_DISK    = 2'd2;
  localparam logic [1:0] INT_INPUT   = 2'd3;

  localparam logic [1:0] KERNEL    = 2'd0;
  localparam logic [1:0] USER      = 2'd1;
  localparam logic [1:0] TAKEN     = 2'd2;
  localparam logic [1:0] SERVICING = 2'd3;

  // Highest-priority pending source: input > disk > quantum.
  function automatic logic [1:0] pick(input logic [3:1] p);
    logic [1:0] c;
    c = INT_NONE;
    if (p[3])      c = INT_INPUT;
    else if (p[2]) c = INT_DISK;
    else if (p[1]) c = INT_QUANTUM;
    return c;
  endfunction

  // Pending-bit mask for a given interrupt code.
  function automatic logic [3:1] code_bit(input logic [1:0] c);
    logic [3:1] m;
    m = 3'b000;
    unique case (c)
      INT_QUANTUM: m = 3'b001;
      INT_DISK:    m = 3'b010;
      INT_INPUT:   m = 3'b100;
      default:     m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/interrupt_controller_quantum_timer.sv
// User-mode time slice counter.
// Loads, decrements to zero, pulses expire on 1->0.
module quantum_timer #(
  parameter int QW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          en,
  input  logic [QW-1:0] value,
  output logic          expire
);

  logic [QW-1:0] count;

  assign expire = en & ~load & (count == QW'(1));

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      count <= '0;
    else if (load)
      count <= value;
    else if (en && count != '0)
      count <= count - QW'(1);
  end

endmodule

// File: rtl/interrupt_controller.sv
// iZero interrupt controller: latches preemption, disk
// and input requests and hands one at a time to control.
module interrupt_controller
  import intc_pkg::*;
#(
  parameter int            QW      = 16,
  parameter logic [QW-1:0] QUANTUM = 16'd1000,
  parameter int            PC_W    = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            userMode,
  input  logic            kernelMode,
  input  logic            inta,
  input  logic            clearIntr,
  input  logic            diskDone,
  input  logic            inputReq,
  input  logic [PC_W-1:0] pc,
  output logic            intr,
  output logic [1:0]      intCode,
  output logic [PC_W-1:0] savedPc,
  output logic            inUser
);

  logic [1:0] state;
  logic [3:1] pend;
  logic [3:1] pend_set;
  logic [3:1] pend_clr;
  logic       s1, s2, s3;
  logic       expire;
  logic       load;
  logic       en;

  assign intr   = (state == TAKEN);
  assign inUser = (state == USER);

  assign load = userMode & (state != TAKEN);
  assign en   = (state == USER) & ~kernelMode & ~userMode;

  quantum_timer #(.QW(QW)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .en     (en),
    .value  (QUANTUM),
    .expire (expire)
  );

  assign pend_set = {s2 & ~s3, diskDone, expire};
  assign pend_clr = (state == TAKEN && inta) ?
                    code_bit(intCode) : 3'b000;

  // Two-flop synchroniser plus history flop for edge detect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= inputReq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Pending bits; a new event beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      pend <= 3'b000;
    else
      pend <= (pend & ~pend_clr) | pend_set;
  end

  // Control FSM with captured code and PC.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= KERNEL;
      intCode <= INT_NONE;
      savedPc <= '0;
    end else begin
      unique case (state)
        KERNEL: begin
          if (userMode) state <= USER;
        end
        USER: begin
          if (kernelMode) begin
            state <= KERNEL;
          end else if (|pend) begin
            state   <= TAKEN;
            intCode <= pick(pend);
            savedPc <= pc;
          end
        end
        TAKEN: begin
          if (inta) state <= SERVICING;
        end
        SERVICING: begin
          if (userMode) begin
            state   <= USER;
            intCode <= INT_NONE;
          end else if (clearIntr) begin
            state   <= KERNEL;
            intCode <= INT_NONE;
          end
        end
        default: state <= KERNEL;
      endcase
    end
  end

endmodule

// File: tb/tb_interrupt_controller.sv
// Randomised scoreboard bench for interrupt_controller.
// Reference model is a cycle-level behavioural description.
module tb_interrupt_controller;

  localparam logic [15:0] Q = 16'd8;
  localparam int M_K = 100;
  localparam int M_U = 101;
  localparam int M_T = 102;
  localparam int M_S = 103;

  logic        clk = 1'b0;
  logic        rst;
  logic        userMode, kernelMode, inta, clearIntr;
  logic        diskDone, inputReq;
  logic [31:0] pc;
  logic        intr;
  logic [1:0]  intCode;
  logic [31:0] savedPc;
  logic        inUser;

  int tests = 0;
  int fails = 0;

  interrupt_controller #(.QW(16), .QUANTUM(Q), .PC_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .userMode   (userMode),
    .kernelMode (kernelMode),
    .inta       (inta),
    .clearIntr  (clearIntr),
    .diskDone   (diskDone),
    .inputReq   (inputReq),
    .pc         (pc),
    .intr       (intr),
    .intCode    (intCode),
    .savedPc    (savedPc),
    .inUser     (inUser)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          code;
    logic [31:0] pc;
  } exp_t;

  exp_t sbq[$];

  int          m_mode;
  int          m_cnt;
  bit          m_p[1:3];
  int          m_code;
  logic [31:0] m_spc;
  bit          h1, h2, h3;
  bit          in_lvl;

  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_K;
    m_cnt  = 0;
    for (int i = 1; i <= 3; i++) m_p[i] = 0;
    m_code = 0;
    m_spc  = '0;
    h1 = 0; h2 = 0; h3 = 0;
    sbq.delete();
  endtask

  // One clock of the reference behaviour.
  task automatic model_step(bit um, bit km, bit ia, bit ci,
                            bit dd, bit ir, logic [31:0] p);
    bit set_in, ex, any;
    bit set[1:3];
    int hi;
    set_in = h2 && !h3;
    h3 = h2; h2 = h1; h1 = ir;
    hi = m_p[3] ? 3 : m_p[2] ? 2 : m_p[1] ? 1 : 0;
    any = (hi != 0);
    ex = (m_mode == M_U) && !km && !um && (m_cnt == 1);
    set[1] = ex; set[2] = dd; set[3] = set_in;
    for (int i = 1; i <= 3; i++) begin
      bit clr;
      clr = (m_mode == M_T) && ia && (m_code == i);
      m_p[i] = (m_p[i] && !clr) || set[i];
    end
    if (um && m_mode != M_T) m_cnt = int'(Q);
    else if (m_mode == M_U && !km && m_cnt > 0) m_cnt--;
    case (m_mode)
      M_K: if (um) m_mode = M_U;
      M_U: begin
        if (km) m_mode = M_K;
        else if (any) begin
          exp_t e;
          m_mode = M_T;
          m_code = hi;
          m_spc  = p;
          e.code = hi;
          e.pc   = p;
          sbq.push_back(e);
        end
      end
      M_T: if (ia) m_mode = M_S;
      M_S: begin
        if (um) begin m_mode = M_U; m_code = 0; end
        else if (ci) begin m_mode = M_K; m_code = 0; end
      end
      default: m_mode = M_K;
    endcase
  endtask

  task automatic cyc(bit um = 0, bit km = 0, bit ia = 0,
                     bit ci = 0, bit dd = 0);
    userMode   = um;
    kernelMode = km;
    inta       = ia;
    clearIntr  = ci;
    diskDone   = dd;
    inputReq   = in_lvl;
    @(posedge clk);
    model_step(um, km, ia, ci, dd, in_lvl, pc);
    @(negedge clk);
    userMode = 0; kernelMode = 0; inta = 0;
    clearIntr = 0; diskDone = 0;
    chk("intr", 32'(intr), 32'(m_mode == M_T));
    chk("inUser", 32'(inUser), 32'(m_mode == M_U));
    chk("intCode", 32'(intCode), 32'(m_code));
    chk("savedPc", savedPc, m_spc);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic do_reset();
    #2 rst = 0;
    #1;
    chk("rst_intr", 32'(intr), 0);
    chk("rst_intCode", 32'(intCode), 0);
    chk("rst_savedPc", savedPc, 0);
    chk("rst_inUser", 32'(inUser), 0);
    model_reset();
    @(negedge clk);
    rst = 1;
  endtask

  // Monitor: every new interrupt presented is checked
  // against the oldest expected entry.
  bit prev_intr = 0;
  always @(negedge clk) begin
    if (!rst) begin
      prev_intr = 0;
    end else begin
      if (intr && !prev_intr) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected", 32'(intr), 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("sb_code", 32'(intCode), 32'(e.code));
          chk("sb_pc", savedPc, e.pc);
        end
      end
      prev_intr = intr;
    end
  end

  initial begin
    rst = 0;
    userMode = 0; kernelMode = 0; inta = 0; clearIntr = 0;
    diskDone = 0; inputReq = 0; pc = 32'h0;
    in_lvl = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("init_intr", 32'(intr), 0);
    chk("init_intCode", 32'(intCode), 0);
    chk("init_inUser", 32'(inUser), 0);
    chk("init_savedPc", savedPc, 0);
    rst = 1;
    @(negedge clk);

    // Quantum preemption.
    pc = 32'h40;
    cyc(1);
    idle(8);
    chk("q_before", 32'(intr), 0);
    idle(1);
    chk("q_intr", 32'(intr), 1);
    chk("q_code", 32'(intCode), 1);
    chk("q_pc", savedPc, 32'h40);
    cyc(0, 0, 1);
    chk("q_inta", 32'(intr), 0);
    cyc(0, 0, 0, 1);
    chk("q_clear", 32'(intCode), 0);
    chk("q_kernel", 32'(inUser), 0);

    // Priority: input beats disk.
    pc = 32'h100;
    cyc(0, 0, 0, 0, 1);
    in_lvl = 1;
    idle(4);
    cyc(1);
    idle(1);
    chk("pri_first", 32'(intCode), 3);
    cyc(0, 0, 1);
    cyc(1);
    idle(1);
    chk("pri_second", 32'(intCode), 2);
    cyc(0, 0, 1);
    cyc(0, 0, 0, 1);

    // Syscall masking with counter held at 5.
    cyc(1);
    idle(3);
    cyc(0, 1);
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("sys_mask", 32'(intr), 0);
    end
    cyc(1);
    idle(8);
    chk("sys_reload", 32'(intr), 0);
    idle(1);
    chk("sys_take", 32'(intCode), 1);
    cyc(0, 0, 1);
    cyc(0, 0, 0, 1);

    // Same-cycle set/clear and strobe collisions.
    in_lvl = 0;
    idle(4);
    cyc(0, 0, 0, 0, 1);
    cyc(1);
    idle(1);
    chk("col_code", 32'(intCode), 2);
    cyc(0, 0, 1, 0, 1);
    cyc(1);
    idle(1);
    chk("col_retake", 32'(intCode), 2);
    chk("col_retake_intr", 32'(intr), 1);
    cyc(0, 0, 1);
    cyc(1, 0, 0, 1);
    chk("col_user", 32'(inUser), 1);
    chk("col_zero", 32'(intCode), 0);
    cyc(0, 1);

    // Input synchroniser latency and single edge.
    cyc(1);
    in_lvl = 1;
    idle(3);
    chk("sync_early", 32'(intr), 0);
    idle(1);
    chk("sync_intr", 32'(intr), 1);
    chk("sync_code", 32'(intCode), 3);
    cyc(0, 0, 1);
    cyc(0, 0, 0, 1);
    idle(50);
    cyc(1);
    idle(2);
    chk("sync_once", 32'(intr), 0);
    cyc(0, 1);
    in_lvl = 0;

    // Asynchronous reset in the middle of an interrupt.
    cyc(0, 0, 0, 0, 1);
    cyc(1);
    idle(1);
    do_reset();

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      int r;
      bit dd;
      r  = $urandom_range(0, 15);
      dd = ($urandom_range(0, 19) == 0);
      pc = $urandom;
      if ($urandom_range(0, 24) == 0) in_lvl = ~in_lvl;
      case (r)
        0: cyc(1, 0, 0, 0, dd);
        1: cyc(0, 1, 0, 0, dd);
        2, 5, 6: cyc(0, 0, 1, 0, dd);
        3: cyc(0, 0, 0, 1, dd);
        4: cyc(1, 0, 0, 1, dd);
        default: cyc(0, 0, 0, 0, dd);
      endcase
      if (n % 1000 == 999) begin
        in_lvl = 0;
        inputReq = 0;
        do_reset();
      end
    end

    cyc(0, 1);
    #1;
    chk("sb_drain", 32'(sbq.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
- Sequential interrupt source for the iZero core. Latches preemption, disk and input requests and prioritises them.
- Drives `intr` and a stable interrupt code into the control unit. Handshakes with the control unit's `inta` (pre_io), `clearIntr` (cic), `userMode` (exec/exec_again) and `kernelMode` (syscall) strobes.
- Captures the interrupted PC for the `gip` read path and the code for the `gic` read path.

Parameters:
- QUANTUM, 16'd1000: user-mode time slice in clock cycles; reload value of the preemption counter.
- QW, 16: width of the quantum counter.
- PC_W, 32: width of the PC capture register.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- userMode  in  1  one-cycle strobe: enter user mode (exec/exec_again)
- kernelMode  in  1  one-cycle strobe: syscall, return to kernel
- inta  in  1  one-cycle interrupt acknowledge (pre_io)
- clearIntr  in  1  one-cycle clear of the stored code (cic)
- diskDone  in  1  one-cycle pulse from the disk unit, synchronous to clk
- inputReq  in  1  asynchronous level from the input switch/button
- pc  in  PC_W  current PC
- intr  out  1  interrupt request to the control unit
- intCode  out  2  0 none, 1 quantum expired, 2 disk done, 3 input
- savedPc  out  PC_W  PC captured when the interrupt is taken
- inUser  out  1  high while in USER state

Behaviour:
- Reset (rst=0, asynchronous):
  - state=KERNEL; counter=0; pending[3:1]=0.
  - intCode=0, intr=0, savedPc=0, inUser=0.
  - synchroniser flops=0.
- Input path:
  - inputReq passes through a 2-flop synchroniser plus a third history flop.
  - A rising edge sets pend_in.
  - Input edge at clock N appears as intr high after edge N+4.
- Disk path:
  - diskDone sampled at edge N sets pend_disk.
  - intr is high after edge N+1 if the controller is already in USER.
- Pending bits:
  - Each bit is set by its event and cleared only when that source is taken (on inta).
  - If a set and a clear hit the same cycle, set wins: the bit stays 1.
- Priority when taking: input (3) > disk (2) > quantum (1).
- KERNEL state:
  - Counter frozen; pending bits still latch; intr=0.
  - userMode → USER; counter loads QUANTUM.
- USER state:
  - Counter decrements by 1 per cycle, saturating at 0.
  - The 1→0 transition sets pend_q.
  - kernelMode → KERNEL; counter held; no interrupt taken that cycle.
  - Otherwise, any pending bit → TAKEN on the next edge. That edge latches intCode (highest priority) and savedPc=pc.
  - kernelMode takes precedence over taking an interrupt in the same cycle.
- TAKEN state:
  - intr=1 (registered, combinational only from state).
  - inta → SERVICING; clears the pending bit matching intCode; intr drops next cycle.
  - Other strobes are ignored.
- SERVICING state:
  - intr=0; intCode and savedPc stable.
  - clearIntr → KERNEL; intCode=0.
  - userMode → USER; intCode=0; counter reloads QUANTUM.
  - If both strobes arrive together, userMode wins.
  - New events keep latching and are taken in the next USER residency.
- userMode in USER: counter reloads QUANTUM (restart of the slice).
- inUser = (state==USER).
- Reset mid-TAKEN/SERVICING: immediate return to reset values; pending events are lost.
- The 16-bit counter never wraps: saturates at 0.

Decomposition:
- Package `intc_pkg`:
  - intCode localparams INT_NONE=0, INT_QUANTUM=1, INT_DISK=2, INT_INPUT=3.
  - State encoding KERNEL=0, USER=1, TAKEN=2, SERVICING=3.
- Sub-module `quantum_timer`: load/enable/saturating decrement, outputs `expire` pulse on 1→0.
- Synchroniser, pending bits and FSM live in the top.

Test Plan:
- Reset with rst=0 mid-run → intr=0, intCode=0, savedPc=0, inUser=0 asynchronously (before the next clk edge).
- Quantum preemption:
  - Stimulus: QUANTUM=8; userMode at cycle 0, pc=0x40.
  - Required: intr=1 after 9 edges, intCode=1, savedPc=0x40.
  - Then inta → intr=0; clearIntr → intCode=0, state KERNEL.
- Priority:
  - Stimulus: diskDone and an inputReq rise while in KERNEL; then userMode.
  - Required: first interrupt intCode=3.
  - After inta plus userMode, second interrupt intCode=2 with no new events.
- Syscall masking:
  - Stimulus: in USER with counter at 5, kernelMode, then 20 idle cycles.
  - Required: intr stays 0, counter stays 5.
  - Then userMode reloads QUANTUM.
- Same-cycle collisions:
  - inta coincident with a new diskDone while intCode=2 → pend_disk stays 1; interrupt retaken after the next userMode.
  - clearIntr with userMode in SERVICING → USER, intCode=0.
- Input synchroniser: inputReq rises at edge 10 in USER → intr=1 visible after edge 14; level held high for 50 cycles → exactly one interrupt.
